// File: rtl/ex_mdu_pkg.sv
// Shared opcodes, bus widths and helpers for the EX-stage multiply/divide unit.
package ex_mdu_pkg;

    localparam int          ALU_OP_W  = 8;
    localparam int          REG_W     = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic        RST_LEVEL = 1'b0;

    localparam logic [ALU_OP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [ALU_OP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [ALU_OP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALU_OP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [ALU_OP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;

    // Two's-complement magnitude when the value is treated as signed.
    function automatic logic [REG_W-1:0] mag(input logic [REG_W-1:0] v, input logic sgn);
        return (sgn && v[REG_W-1]) ? (ZERO_WORD - v) : v;
    endfunction

endpackage

// File: rtl/ex_mdu_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes; 32 iterations after start.
module div_iter
    import ex_mdu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [REG_W-1:0] dividend_i,
    input  logic [REG_W-1:0] divisor_i,
    output logic             done_o,
    output logic [63:0]      result_o
);

    logic [5:0]       cnt_q;
    logic [REG_W-1:0] rem_q;
    logic [REG_W-1:0] quo_q;
    logic [REG_W-1:0] dvs_q;
    logic [REG_W:0]   trial;

    assign trial = {rem_q, quo_q[REG_W-1]} - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (abort_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= 6'd32;
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (cnt_q != 6'd0) begin
            cnt_q <= cnt_q - 6'd1;
            // Negative trial (borrow out) means restore: keep the shifted remainder.
            if (!trial[REG_W]) begin
                rem_q <= trial[REG_W-1:0];
                quo_q <= {quo_q[REG_W-2:0], 1'b1};
            end else begin
                rem_q <= {rem_q[REG_W-2:0], quo_q[REG_W-1]};
                quo_q <= {quo_q[REG_W-2:0], 1'b0};
            end
        end
    end

    // Final iteration is in progress; the result is stable from the next cycle on.
    assign done_o   = (cnt_q == 6'd1);
    assign result_o = {rem_q, quo_q};

endmodule

// File: rtl/ex_mdu.sv
// EX-stage HI/LO unit: single-cycle multiply, 32-cycle iterative divide, MTHI/MTLO.
// state | meaning
// IDLE  | waiting for a start code; MTHI/MTLO handled here
// MUL   | one-cycle product capture
// DIV   | div_iter running 32 iterations
// DONE  | write HI/LO (unless divide by zero), back to IDLE
module ex_mdu
    import ex_mdu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ALU_OP_W-1:0] ex_aluop,
    input  logic [REG_W-1:0]    ex_reg1_data,
    input  logic [REG_W-1:0]    ex_reg2_data,
    input  logic                flush,
    output logic                stallreq,
    output logic [REG_W-1:0]    hi_o,
    output logic [REG_W-1:0]    lo_o,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    state_e           state_q, state_d;
    logic [REG_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [REG_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [63:0]      prod_q, prod_d;
    logic             sgn_q, sgn_d, wr_q, wr_d, is_div_q, is_div_d;

    logic        is_mul_op, is_div_op, op_sgn;
    logic        div_start, div_done;
    logic [63:0] div_res, prod_s, prod_u;
    logic [31:0] quo_fix, rem_fix;

    assign is_mul_op = (ex_aluop == EXE_MULT_OP) || (ex_aluop == EXE_MULTU_OP);
    assign is_div_op = (ex_aluop == EXE_DIV_OP)  || (ex_aluop == EXE_DIVU_OP);
    assign op_sgn    = (ex_aluop == EXE_MULT_OP) || (ex_aluop == EXE_DIV_OP);

    assign prod_s = $signed({{32{op_a_q[31]}}, op_a_q}) * $signed({{32{op_b_q[31]}}, op_b_q});
    assign prod_u = {32'd0, op_a_q} * {32'd0, op_b_q};

    div_iter u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .abort_i    (flush),
        .dividend_i (mag(ex_reg1_data, op_sgn)),
        .divisor_i  (mag(ex_reg2_data, op_sgn)),
        .done_o     (div_done),
        .result_o   (div_res)
    );

    assign quo_fix = (sgn_q && (op_a_q[31] ^ op_b_q[31])) ? (ZERO_WORD - div_res[31:0]) : div_res[31:0];
    assign rem_fix = (sgn_q && op_a_q[31]) ? (ZERO_WORD - div_res[63:32]) : div_res[63:32];

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        prod_d    = prod_q;
        sgn_d     = sgn_q;
        wr_d      = wr_q;
        is_div_d  = is_div_q;
        stallreq  = 1'b0;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mul_op || is_div_op) begin
                    op_a_d   = ex_reg1_data;
                    op_b_d   = ex_reg2_data;
                    sgn_d    = op_sgn;
                    is_div_d = is_div_op;
                    stallreq = 1'b1;
                    if (is_mul_op) begin
                        wr_d    = 1'b1;
                        state_d = MUL;
                    end else if (ex_reg2_data == ZERO_WORD) begin
                        wr_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        wr_d      = 1'b1;
                        div_start = 1'b1;
                        state_d   = DIV;
                    end
                end else if (ex_aluop == EXE_MTHI_OP) begin
                    hi_d = ex_reg1_data;
                end else if (ex_aluop == EXE_MTLO_OP) begin
                    lo_d = ex_reg1_data;
                end
            end
            MUL: begin
                stallreq = 1'b1;
                prod_d   = sgn_q ? prod_s : prod_u;
                state_d  = DONE;
            end
            DIV: begin
                stallreq = 1'b1;
                if (div_done) state_d = DONE;
            end
            DONE: begin
                if (wr_q) begin
                    hi_d = is_div_q ? rem_fix : prod_q[63:32];
                    lo_d = is_div_q ? quo_fix : prod_q[31:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d   = IDLE;
            hi_d      = hi_q;
            lo_d      = lo_q;
            stallreq  = 1'b0;
            div_start = 1'b0;
        end
        // A start code seen while reset is held must not stall the pipeline.
        if (rst == RST_LEVEL) stallreq = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            hi_q     <= ZERO_WORD;
            lo_q     <= ZERO_WORD;
            op_a_q   <= ZERO_WORD;
            op_b_q   <= ZERO_WORD;
            prod_q   <= '0;
            sgn_q    <= 1'b0;
            wr_q     <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            prod_q   <= prod_d;
            sgn_q    <= sgn_d;
            wr_q     <= wr_d;
            is_div_q <= is_div_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: multiply, divide, divide-by-zero, flush, MTHI/MTLO, reset.
module tb_ex_mdu;
    import ex_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_reg1_data;
    logic [31:0] ex_reg2_data;
    logic        flush;
    logic        stallreq;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int n;

    localparam logic [7:0] NOP = 8'h00;

    ex_mdu dut (
        .clk          (clk),
        .rst          (rst),
        .ex_aluop     (ex_aluop),
        .ex_reg1_data (ex_reg1_data),
        .ex_reg2_data (ex_reg2_data),
        .flush        (flush),
        .stallreq     (stallreq),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        ex_aluop     = op;
        ex_reg1_data = a;
        ex_reg2_data = b;
        #1;
    endtask

    // Hold the instruction while stalled, then run DONE and its exit edge.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stall,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        drive(op, a, b);
        n = 0;
        while (stallreq === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk({tag, "_stall"}, n, exp_stall);
        chk({tag, "_done_busy"}, busy, 1'b1);
        tick();
        chk({tag, "_idle"}, busy, 1'b0);
        drive(NOP, 32'h0, 32'h0);
        chk({tag, "_hi"}, hi_o, exp_hi);
        chk({tag, "_lo"}, lo_o, exp_lo);
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        drive(EXE_MULT_OP, 32'h1, 32'h1);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stallreq, 1'b0);
        tick();
        tick();
        drive(NOP, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        chk("post_rst_busy", busy, 1'b0);

        run_op("mult", EXE_MULT_OP, 32'hFFFF_FFFE, 32'h0000_0003, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div", EXE_DIV_OP, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'h0000_0002, 32'h0000_000E);
        run_op("div7s", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divz", EXE_DIVU_OP, 32'd55, 32'd0, 1, 32'h0000_0001, 32'hFFFF_FFFD);

        // Flush in the tenth DIV cycle.
        drive(EXE_DIVU_OP, 32'd1000, 32'd3);
        tick();
        for (int i = 0; i < 9; i++) tick();
        chk("flush_pre_busy", busy, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_stall", stallreq, 1'b0);
        tick();
        flush = 1'b0;
        drive(NOP, 32'h0, 32'h0);
        chk("flush_busy", busy, 1'b0);
        chk("flush_idle_stall", stallreq, 1'b0);
        chk("flush_hi", hi_o, 32'h0000_0001);
        chk("flush_lo", lo_o, 32'hFFFF_FFFD);

        drive(EXE_MTLO_OP, 32'h1234_5678, 32'h0);
        chk("mtlo_stall", stallreq, 1'b0);
        tick();
        chk("mtlo_lo", lo_o, 32'h1234_5678);
        chk("mtlo_hi", hi_o, 32'h0000_0001);
        drive(EXE_MTHI_OP, 32'hAABB_CCDD, 32'h0);
        chk("mthi_stall", stallreq, 1'b0);
        tick();
        chk("mthi_hi", hi_o, 32'hAABB_CCDD);
        chk("mthi_lo", lo_o, 32'h1234_5678);

        drive(8'h2A, 32'hDEAD_BEEF, 32'h0);
        tick();
        chk("unk_busy", busy, 1'b0);
        chk("unk_hi", hi_o, 32'hAABB_CCDD);
        chk("unk_lo", lo_o, 32'h1234_5678);

        // Asynchronous reset in the middle of a divide.
        drive(EXE_DIVU_OP, 32'd999, 32'd10);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_hi", hi_o, 32'h0);
        chk("arst_lo", lo_o, 32'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_stall", stallreq, 1'b0);
        drive(NOP, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("arst_rel_busy", busy, 1'b0);
        chk("arst_rel_lo", lo_o, 32'h0);

        run_op("multu2", EXE_MULTU_OP, 32'd5, 32'd7, 2, 32'h0, 32'd35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
